// File: rtl/acfa_cflog_ctrl_pkg.sv
// Shared definitions for the ACFA control-flow log controller.
//   state_t          controller states (IDLE, RUN, FLUSH, FINAL, VIOL)
//   ENTRY_WORDS      16-bit words per log entry (src, dest, cnt)
//   log_region_last  last byte address covered by a log of `depth` entries
package acfa_cflog_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_FINAL = 3'd3,
        ST_VIOL  = 3'd4
    } state_t;

    localparam int ENTRY_WORDS = 3;

    // Each entry is ENTRY_WORDS words of 2 bytes each.
    function automatic logic [15:0] log_region_last(input logic [15:0] base, input int depth);
        return base + 16'(ENTRY_WORDS * 2 * depth - 1);
    endfunction

endpackage

// File: rtl/acfa_cflog_range.sv
// Inclusive address window check: hit = lo <= addr <= hi.
// Ports:
//   addr  in  16  address under test
//   lo    in  16  window start (inclusive)
//   hi    in  16  window end (inclusive)
//   hit   out 1   address lies inside the window
module acfa_cflog_range (
    input  logic [15:0] addr,
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    output logic        hit
);

    assign hit = (addr >= lo) && (addr <= hi);

endmodule

// File: rtl/acfa_cflog_ctrl.sv
// Control-flow log controller. Records (src,dest) branch pairs taken inside
// the attested region into a ring-buffer log, compressing back-to-back repeats,
// halting the core while the log is flushed, and requesting a core reset on
// any protocol or write-protection violation.
// Ports:
//   clk, puc                      clock, asynchronous active-high reset
//   pc, pc_nxt, cf_valid          current/next PC and non-sequential transfer strobe
//   data_wr, data_addr            CPU data write
//   dma_en, dma_addr              DMA access
//   er_min, er_max                attested region bounds (inclusive)
//   flush_ack                     log consumer finished draining
//   log_wen, log_ptr, log_src,
//   log_dest, log_cnt             entry write port
//   flush_req, cpu_halt           flush handshake / core stall
//   boot, er_done                 region entry / exit pulses
//   reset                         violation reset request (sticky until puc)
module acfa_cflog_ctrl
    import acfa_cflog_ctrl_pkg::*;
#(
    parameter logic [15:0] LOG_BASE      = 16'h0240,
    parameter int          LOG_DEPTH     = 64,
    parameter int          WATERMARK     = LOG_DEPTH - 1,
    parameter bit          LOOP_COMPRESS = 1'b1,
    parameter int          CNT_W         = 16,
    localparam int         PTR_W         = $clog2(LOG_DEPTH)
) (
    input  logic             clk,
    input  logic             puc,
    input  logic [15:0]      pc,
    input  logic [15:0]      pc_nxt,
    input  logic             cf_valid,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic             dma_en,
    input  logic [15:0]      dma_addr,
    input  logic [15:0]      er_min,
    input  logic [15:0]      er_max,
    input  logic             flush_ack,
    output logic             log_wen,
    output logic [PTR_W-1:0] log_ptr,
    output logic [15:0]      log_src,
    output logic [15:0]      log_dest,
    output logic [CNT_W-1:0] log_cnt,
    output logic             flush_req,
    output logic             cpu_halt,
    output logic             boot,
    output logic             er_done,
    output logic             reset
);

    localparam logic [15:0]      LOG_LAST = log_region_last(LOG_BASE, LOG_DEPTH);
    localparam logic [PTR_W-1:0] WM_IDX   = PTR_W'(WATERMARK);

    // Window checks: 0 = pc in ER, 1 = pc_nxt in ER, 2 = CPU write in log, 3 = DMA in log.
    logic [15:0] chk_addr [4];
    logic [15:0] chk_lo   [4];
    logic [15:0] chk_hi   [4];
    logic [3:0]  chk_hit;

    assign chk_addr[0] = pc;
    assign chk_addr[1] = pc_nxt;
    assign chk_addr[2] = data_addr;
    assign chk_addr[3] = dma_addr;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_range
            assign chk_lo[gi] = (gi < 2) ? er_min : LOG_BASE;
            assign chk_hi[gi] = (gi < 2) ? er_max : LOG_LAST;
            acfa_cflog_range u_range (
                .addr (chk_addr[gi]),
                .lo   (chk_lo[gi]),
                .hi   (chk_hi[gi]),
                .hit  (chk_hit[gi])
            );
        end
    endgenerate

    logic pc_in_er, nxt_in_er, prot_viol;
    assign pc_in_er  = chk_hit[0];
    assign nxt_in_er = chk_hit[1];
    assign prot_viol = (data_wr && chk_hit[2]) || (dma_en && chk_hit[3]);

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   log_ptr_reg;
    logic               first_reg;        // next new entry goes to index 0
    logic [15:0]        log_src_reg, log_dest_reg;  // also serve as the last-pair record
    logic [CNT_W-1:0]   log_cnt_reg;
    logic               log_wen_reg, boot_reg, er_done_reg;
    logic               skid_valid_reg;
    logic [15:0]        skid_src_reg, skid_dest_reg;

    // Event decode
    logic cf_log, entry_ok, entry_bad, exit_ok, exit_bad, ack_flush, skid_overflow;
    assign cf_log        = cf_valid && pc_in_er;
    assign entry_ok      = (state_reg == ST_IDLE) && !pc_in_er && (pc_nxt == er_min);
    assign entry_bad     = (state_reg == ST_IDLE) && !pc_in_er && nxt_in_er && (pc_nxt != er_min);
    assign exit_ok       = (state_reg == ST_RUN) && (pc == er_max) && !nxt_in_er;
    assign exit_bad      = (state_reg == ST_RUN) && pc_in_er && !nxt_in_er && (pc != er_max);
    assign ack_flush     = (state_reg == ST_FLUSH) && flush_ack;
    assign skid_overflow = (state_reg == ST_FLUSH) && cf_log && skid_valid_reg;

    // Entry write decode. On flush_ack the buffered (or simultaneous) event is
    // written straight away at index 0 of the freshly emptied log.
    logic             wr_req, wr_first, wr_compress, wr_full;
    logic [15:0]      wr_src, wr_dest;
    logic [PTR_W-1:0] wr_idx;

    always_comb begin
        wr_req      = ((state_reg == ST_RUN) && cf_log) ||
                      (ack_flush && (skid_valid_reg || cf_log));
        wr_src      = (ack_flush && skid_valid_reg) ? skid_src_reg  : pc;
        wr_dest     = (ack_flush && skid_valid_reg) ? skid_dest_reg : pc_nxt;
        wr_first    = first_reg || ack_flush;
        // A saturated counter starts a fresh entry instead of wrapping.
        wr_compress = LOOP_COMPRESS && !wr_first && (wr_src == log_src_reg) &&
                      (wr_dest == log_dest_reg) && (log_cnt_reg != '1);
        wr_idx      = wr_compress ? log_ptr_reg : (wr_first ? '0 : log_ptr_reg + PTR_W'(1));
        wr_full     = wr_req && (wr_idx == WM_IDX);
    end

    // State register
    always_ff @(posedge clk or posedge puc) begin
        if (puc) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (entry_bad) state_next = ST_VIOL;
                      else if (entry_ok) state_next = ST_RUN;
            ST_RUN:   if (exit_bad) state_next = ST_VIOL;
                      else if (exit_ok) state_next = ST_FINAL;
                      else if (wr_full) state_next = ST_FLUSH;
            ST_FLUSH: if (skid_overflow) state_next = ST_VIOL;
                      else if (flush_ack) state_next = wr_full ? ST_FLUSH : ST_RUN;
            ST_FINAL: if (flush_ack) state_next = ST_IDLE;
            ST_VIOL:  state_next = ST_VIOL;
            default:  state_next = ST_IDLE;
        endcase
        if (prot_viol) state_next = ST_VIOL;
    end

    // Log datapath, skid buffer and pulse registers
    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            log_ptr_reg    <= '0;
            first_reg      <= 1'b1;
            log_src_reg    <= '0;
            log_dest_reg   <= '0;
            log_cnt_reg    <= '0;
            log_wen_reg    <= 1'b0;
            boot_reg       <= 1'b0;
            er_done_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_src_reg   <= '0;
            skid_dest_reg  <= '0;
        end else begin
            boot_reg    <= (state_reg == ST_IDLE) && (state_next == ST_RUN);
            er_done_reg <= (state_reg == ST_RUN) && (state_next == ST_FINAL);
            log_wen_reg <= wr_req;
            if (entry_ok) begin
                log_ptr_reg <= '0;
                first_reg   <= 1'b1;
            end
            if (ack_flush) begin
                log_ptr_reg    <= '0;
                first_reg      <= 1'b1;
                log_src_reg    <= '0;
                log_dest_reg   <= '0;
                log_cnt_reg    <= '0;
                skid_valid_reg <= 1'b0;
            end
            if (wr_req) begin
                log_ptr_reg  <= wr_idx;
                first_reg    <= 1'b0;
                log_src_reg  <= wr_src;
                log_dest_reg <= wr_dest;
                log_cnt_reg  <= wr_compress ? log_cnt_reg + CNT_W'(1) : CNT_W'(1);
            end
            if ((state_reg == ST_FLUSH) && cf_log && !skid_valid_reg && !flush_ack) begin
                skid_valid_reg <= 1'b1;
                skid_src_reg   <= pc;
                skid_dest_reg  <= pc_nxt;
            end
        end
    end

    // Outputs
    always_comb begin
        log_wen   = log_wen_reg && (state_reg != ST_VIOL);
        flush_req = (state_reg == ST_FLUSH) || (state_reg == ST_FINAL);
        cpu_halt  = (state_reg == ST_FLUSH);
        reset     = (state_reg == ST_VIOL);
        boot      = boot_reg;
        er_done   = er_done_reg;
        log_ptr   = log_ptr_reg;
        log_src   = log_src_reg;
        log_dest  = log_dest_reg;
        log_cnt   = log_cnt_reg;
    end

endmodule

// File: tb/tb_acfa_cflog_ctrl.sv
// Bench for acfa_cflog_ctrl: directed vector table, hand sequences for reset
// and DMA protection, then randomized episodes checked against an entry-list model.
module tb_acfa_cflog_ctrl;

    localparam int          DEPTH  = 4;
    localparam int          CW     = 2;
    localparam logic [15:0] LB     = 16'h0240;
    localparam logic [15:0] ER_MIN = 16'hE100;
    localparam logic [15:0] ER_MAX = 16'hE1FF;

    logic clk = 1'b0;
    logic puc;
    logic [15:0] pc, pc_nxt, data_addr, dma_addr, er_min, er_max;
    logic cf_valid, data_wr, dma_en, flush_ack;
    logic log_wen, flush_req, cpu_halt, boot, er_done, reset;
    logic [1:0] log_ptr;
    logic [15:0] log_src, log_dest;
    logic [CW-1:0] log_cnt;

    acfa_cflog_ctrl #(
        .LOG_BASE(LB), .LOG_DEPTH(DEPTH), .WATERMARK(DEPTH - 1),
        .LOOP_COMPRESS(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .puc(puc), .pc(pc), .pc_nxt(pc_nxt), .cf_valid(cf_valid),
        .data_wr(data_wr), .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr),
        .er_min(er_min), .er_max(er_max), .flush_ack(flush_ack),
        .log_wen(log_wen), .log_ptr(log_ptr), .log_src(log_src), .log_dest(log_dest),
        .log_cnt(log_cnt), .flush_req(flush_req), .cpu_halt(cpu_halt), .boot(boot),
        .er_done(er_done), .reset(reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] p, input logic [15:0] n, input logic cf);
        pc = p; pc_nxt = n; cf_valid = cf;
        data_wr = 1'b0; data_addr = 16'h0300; dma_en = 1'b0; dma_addr = 16'h0300; flush_ack = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] pc, nxt; logic cf, wr; logic [15:0] waddr; logic ack;
        logic e_wen; int e_ptr; logic [15:0] e_src, e_dst; int e_cnt;
        logic e_freq, e_halt, e_boot, e_done, e_rst;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic [15:0] p, n, input logic cf, wr, input logic [15:0] wa,
                               input logic ack, wen, input int ptr, input logic [15:0] s, d,
                               input int cnt, input logic fr, hl, bt, dn, rs);
        vec_t r;
        r.pc = p; r.nxt = n; r.cf = cf; r.wr = wr; r.waddr = wa; r.ack = ack;
        r.e_wen = wen; r.e_ptr = ptr; r.e_src = s; r.e_dst = d; r.e_cnt = cnt;
        r.e_freq = fr; r.e_halt = hl; r.e_boot = bt; r.e_done = dn; r.e_rst = rs;
        return r;
    endfunction

    // ---------------- reference model ----------------
    localparam int M_OUT = 0, M_IN = 1, M_HALT = 2, M_END = 3, M_BAD = 4;
    int mode;
    logic [15:0] ent_src[$], ent_dst[$];
    int ent_cnt[$];
    logic [15:0] pend_src[$], pend_dst[$];
    logic x_wen, x_boot, x_done;
    logic [15:0] x_src, x_dst;
    int x_cnt;
    logic [15:0] pool [4];

    function automatic bit in_er(input logic [15:0] a);
        return (a >= ER_MIN) && (a <= ER_MAX);
    endfunction

    function automatic bit in_log(input logic [15:0] a);
        return (int'(a) >= int'(LB)) && (int'(a) < int'(LB) + 6 * DEPTH);
    endfunction

    task automatic model_reset();
        mode = M_OUT;
        ent_src.delete(); ent_dst.delete(); ent_cnt.delete();
        pend_src.delete(); pend_dst.delete();
    endtask

    task automatic model_log(input logic [15:0] s, input logic [15:0] d);
        int last;
        last = ent_src.size() - 1;
        if (last >= 0 && ent_src[last] == s && ent_dst[last] == d && ent_cnt[last] < (1 << CW) - 1)
            ent_cnt[last]++;
        else begin
            ent_src.push_back(s); ent_dst.push_back(d); ent_cnt.push_back(1);
        end
        last = ent_src.size() - 1;
        x_wen = 1'b1; x_src = s; x_dst = d; x_cnt = ent_cnt[last];
    endtask

    task automatic model_cycle();
        bit cfl;
        cfl = cf_valid && in_er(pc);
        x_wen = 1'b0; x_boot = 1'b0; x_done = 1'b0;
        case (mode)
            M_OUT: begin
                if (!in_er(pc) && pc_nxt == ER_MIN) begin
                    x_boot = 1'b1;
                    ent_src.delete(); ent_dst.delete(); ent_cnt.delete();
                    mode = M_IN;
                end else if (!in_er(pc) && in_er(pc_nxt)) mode = M_BAD;
            end
            M_IN: begin
                if (cfl) model_log(pc, pc_nxt);
                if (in_er(pc) && !in_er(pc_nxt)) begin
                    if (pc == ER_MAX) begin x_done = 1'b1; mode = M_END; end
                    else mode = M_BAD;
                end else if (ent_src.size() == DEPTH) mode = M_HALT;
            end
            M_HALT: begin
                if (cfl) begin
                    if (pend_src.size() != 0) mode = M_BAD;
                    else begin pend_src.push_back(pc); pend_dst.push_back(pc_nxt); end
                end
                if (mode == M_HALT && flush_ack) begin
                    ent_src.delete(); ent_dst.delete(); ent_cnt.delete();
                    if (pend_src.size() != 0) model_log(pend_src.pop_front(), pend_dst.pop_front());
                    mode = (ent_src.size() == DEPTH) ? M_HALT : M_IN;
                end
            end
            M_END: if (flush_ack) mode = M_OUT;
            default: ;
        endcase
        if ((data_wr && in_log(data_addr)) || (dma_en && in_log(dma_addr))) begin
            mode = M_BAD; x_boot = 1'b0; x_done = 1'b0;
        end
        if (mode == M_BAD) x_wen = 1'b0;
    endtask

    task automatic model_compare();
        chk("rnd_wen",  log_wen,   x_wen);
        chk("rnd_boot", boot,      x_boot);
        chk("rnd_done", er_done,   x_done);
        chk("rnd_freq", flush_req, (mode == M_HALT || mode == M_END));
        chk("rnd_halt", cpu_halt,  (mode == M_HALT));
        chk("rnd_rst",  reset,     (mode == M_BAD));
        if (mode != M_BAD)
            chk("rnd_ptr", log_ptr, (ent_src.size() == 0) ? 0 : ent_src.size() - 1);
        if (x_wen) begin
            chk("rnd_src", log_src,  x_src);
            chk("rnd_dst", log_dest, x_dst);
            chk("rnd_cnt", log_cnt,  x_cnt);
        end
    endtask

    task automatic apply_reset();
        puc = 1'b1;
        drive(16'hE000, 16'hE002, 1'b0);
        step(); step();
        puc = 1'b0;
        model_reset();
    endtask

    initial begin
        er_min = ER_MIN; er_max = ER_MAX;
        pool[0] = 16'hE110; pool[1] = 16'hE120; pool[2] = 16'hE120; pool[3] = 16'hE1FF;

        // Reset state
        apply_reset();
        chk("rst_wen", log_wen, 0);   chk("rst_ptr", log_ptr, 0);
        chk("rst_src", log_src, 0);   chk("rst_cnt", log_cnt, 0);
        chk("rst_freq", flush_req, 0); chk("rst_halt", cpu_halt, 0);
        chk("rst_boot", boot, 0);     chk("rst_rst", reset, 0);

        //         pc       nxt      cf wr waddr    ack | wen ptr src      dst      cnt fr hl bt dn rs
        tbl.push_back(v(16'hE000, ER_MIN,  0, 0, 16'h0300, 0, 0, 0, 0,       0,       0, 0, 0, 1, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 0, 1, 0, 16'hE110, 16'hE120, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 0, 1, 0, 16'hE110, 16'hE120, 2, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 0, 1, 0, 16'hE110, 16'hE120, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 0, 1, 1, 16'hE110, 16'hE120, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE120, 16'hE130, 1, 0, 16'h0300, 0, 1, 2, 16'hE120, 16'hE130, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE130, 16'hE140, 1, 0, 16'h0300, 0, 1, 3, 16'hE130, 16'hE140, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(16'hE140, 16'hE150, 1, 0, 16'h0300, 0, 0, 3, 0,       0,       0, 1, 1, 0, 0, 0));
        tbl.push_back(v(16'hE140, 16'hE142, 0, 0, 16'h0300, 0, 0, 3, 0,       0,       0, 1, 1, 0, 0, 0));
        tbl.push_back(v(16'hE140, 16'hE142, 0, 0, 16'h0300, 1, 1, 0, 16'hE140, 16'hE150, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 0, 1, 1, 16'hE110, 16'hE120, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(ER_MAX,  16'hE000, 0, 0, 16'h0300, 0, 0, 1, 0,       0,       0, 1, 0, 0, 1, 0));
        tbl.push_back(v(16'hE000, 16'hE002, 0, 0, 16'h0300, 0, 0, 1, 0,       0,       0, 1, 0, 0, 0, 0));
        tbl.push_back(v(16'hE000, 16'hE002, 0, 0, 16'h0300, 1, 0, 1, 0,       0,       0, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE000, ER_MIN,  0, 0, 16'h0300, 0, 0, 0, 0,       0,       0, 0, 0, 1, 0, 0));
        tbl.push_back(v(16'hE110, 16'hE120, 1, 0, 16'h0300, 1, 1, 0, 16'hE110, 16'hE120, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE120, 16'hE122, 0, 1, 16'h0258, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE120, 16'hE122, 0, 1, 16'h023E, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 0));
        tbl.push_back(v(16'hE120, 16'hE122, 0, 1, 16'h0242, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(v(16'hE120, 16'hE122, 0, 0, 16'h0300, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pc, tbl[i].nxt, tbl[i].cf);
            data_wr = tbl[i].wr; data_addr = tbl[i].waddr; flush_ack = tbl[i].ack;
            step();
            $display("vec %0d: wen=%0b ptr=%0d cnt=%0d freq=%0b halt=%0b boot=%0b done=%0b rst=%0b",
                     i, log_wen, log_ptr, log_cnt, flush_req, cpu_halt, boot, er_done, reset);
            chk($sformatf("vec%0d_wen", i),  log_wen,   tbl[i].e_wen);
            chk($sformatf("vec%0d_freq", i), flush_req, tbl[i].e_freq);
            chk($sformatf("vec%0d_halt", i), cpu_halt,  tbl[i].e_halt);
            chk($sformatf("vec%0d_boot", i), boot,      tbl[i].e_boot);
            chk($sformatf("vec%0d_done", i), er_done,   tbl[i].e_done);
            chk($sformatf("vec%0d_rst", i),  reset,     tbl[i].e_rst);
            if (!tbl[i].e_rst) chk($sformatf("vec%0d_ptr", i), log_ptr, tbl[i].e_ptr);
            if (tbl[i].e_wen) begin
                chk($sformatf("vec%0d_src", i), log_src,  tbl[i].e_src);
                chk($sformatf("vec%0d_dst", i), log_dest, tbl[i].e_dst);
                chk($sformatf("vec%0d_cnt", i), log_cnt,  tbl[i].e_cnt);
            end
        end

        // puc while flushing: outputs clear without a clock edge
        apply_reset();
        drive(16'hE000, ER_MIN, 1'b0); step();
        for (int i = 0; i < DEPTH; i++) begin
            drive(16'hE110 + 16'(i * 16), 16'hE180, 1'b1); step();
        end
        drive(16'hE110, 16'hE112, 1'b0); step();
        chk("flush_halt_before_puc", cpu_halt, 1);
        #2 puc = 1'b1;
        #1;
        $display("puc mid-flush: freq=%0b halt=%0b ptr=%0d wen=%0b", flush_req, cpu_halt, log_ptr, log_wen);
        chk("puc_freq", flush_req, 0); chk("puc_halt", cpu_halt, 0);
        chk("puc_ptr", log_ptr, 0);    chk("puc_wen", log_wen, 0);
        step(); puc = 1'b0;
        drive(16'hE000, ER_MIN, 1'b0); step();
        chk("puc_idle_reboot", boot, 1);

        // DMA protection boundary at the last log byte
        drive(16'hE110, 16'hE112, 1'b0); dma_en = 1'b1; dma_addr = 16'h0258; step();
        chk("dma_past_end", reset, 0);
        drive(16'hE110, 16'hE112, 1'b0); dma_en = 1'b1; dma_addr = 16'h0257; step();
        $display("dma to 0257: reset=%0b", reset);
        chk("dma_last_byte", reset, 1);

        // Randomized episodes against the model
        for (int ep = 0; ep < 30; ep++) begin
            apply_reset();
            for (int c = 0; c < 60; c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 65)      begin pc = pool[$urandom_range(0, 3)]; pc_nxt = pool[$urandom_range(0, 3)]; end
                else if (r < 77) begin pc = 16'hE000; pc_nxt = ER_MIN; end
                else if (r < 83) begin pc = ER_MAX;   pc_nxt = 16'hE000; end
                else if (r < 85) begin pc = 16'hE130; pc_nxt = 16'hE300; end
                else if (r < 87) begin pc = 16'hE000; pc_nxt = 16'hE180; end
                else             begin pc = 16'hE000; pc_nxt = 16'hE050; end
                cf_valid  = 1'($urandom_range(0, 1));
                flush_ack = ($urandom_range(0, 3) == 0);
                data_wr   = ($urandom_range(0, 79) == 0);
                data_addr = ($urandom_range(0, 1) == 1) ? 16'(int'(LB) + $urandom_range(0, 6 * DEPTH - 1)) : 16'h0300;
                dma_en    = ($urandom_range(0, 79) == 0);
                dma_addr  = 16'(int'(LB) + $urandom_range(0, 6 * DEPTH + 1)) - 16'd1;
                model_cycle();
                step();
                $display("rnd ep%0d c%0d: pc=%h nxt=%h cf=%0b ack=%0b -> wen=%0b ptr=%0d freq=%0b rst=%0b",
                         ep, c, pc, pc_nxt, cf_valid, flush_ack, log_wen, log_ptr, flush_req, reset);
                model_compare();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
